// File: rtl/fetch2_decode_queue.sv
// Circular queue between fetch stage 2 and decode: compacts up to four valid
// lanes per bundle on enqueue and presents the four oldest entries to decode.
module fetch2_decode_queue #(
    parameter int PKT_W = 133,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fs2Ready_i,
    input  logic             inst0Valid_i,
    input  logic             inst1Valid_i,
    input  logic             inst2Valid_i,
    input  logic             inst3Valid_i,
    input  logic [PKT_W-1:0] inst0Packet_i,
    input  logic [PKT_W-1:0] inst1Packet_i,
    input  logic [PKT_W-1:0] inst2Packet_i,
    input  logic [PKT_W-1:0] inst3Packet_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             fetchStall_o,
    output logic             decodeReady_o,
    output logic             out0Valid_o,
    output logic             out1Valid_o,
    output logic             out2Valid_o,
    output logic             out3Valid_o,
    output logic [PKT_W-1:0] out0Packet_o,
    output logic [PKT_W-1:0] out1Packet_o,
    output logic [PKT_W-1:0] out2Packet_o,
    output logic [PKT_W-1:0] out3Packet_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];

    logic [3:0]       lane_valid_s;
    logic [PKT_W-1:0] lane_pkt_s [4];
    logic [1:0]       lane_pos_s [4];
    logic [2:0]       enq_cnt_s;
    logic [2:0]       deq_cnt_s;
    logic             enq_s;
    logic             deq_s;
    logic [3:0]       out_valid_s;
    logic [PKT_W-1:0] out_pkt_s [4];

    assign lane_valid_s  = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign lane_pkt_s[0] = inst0Packet_i;
    assign lane_pkt_s[1] = inst1Packet_i;
    assign lane_pkt_s[2] = inst2Packet_i;
    assign lane_pkt_s[3] = inst3Packet_i;

    // Lane compaction offsets, enqueue/dequeue amounts and next pointer state.
    always_comb begin
        lane_pos_s[0] = 2'd0;
        lane_pos_s[1] = {1'b0, lane_valid_s[0]};
        lane_pos_s[2] = {1'b0, lane_valid_s[0]} + {1'b0, lane_valid_s[1]};
        lane_pos_s[3] = {1'b0, lane_valid_s[0]} + {1'b0, lane_valid_s[1]}
                      + {1'b0, lane_valid_s[2]};
        enq_cnt_s     = {2'b00, lane_valid_s[0]} + {2'b00, lane_valid_s[1]}
                      + {2'b00, lane_valid_s[2]} + {2'b00, lane_valid_s[3]};

        // Stall leaves room for a full four-wide bundle regardless of its valids.
        fetchStall_o = (count_q > CNT_W'(DEPTH - 4));
        enq_s        = fs2Ready_i & ~fetchStall_o & ~flush_i;
        deq_s        = ~stall_i & ~flush_i;

        if (!deq_s) begin
            deq_cnt_s = 3'd0;
        end else if (count_q >= CNT_W'(4)) begin
            deq_cnt_s = 3'd4;
        end else begin
            deq_cnt_s = count_q[2:0];
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_cnt_s);
            tail_d  = tail_q + PTR_W'(enq_s ? enq_cnt_s : 3'd0);
            count_d = count_q - CNT_W'(deq_cnt_s) + CNT_W'(enq_s ? enq_cnt_s : 3'd0);
        end
    end

    // Per-entry write selection: entry e takes the lane whose compacted slot lands on it.
    always_comb begin : write_sel
        logic       hit;
        logic       hit_any;
        logic [1:0] sel;
        for (int e = 0; e < DEPTH; e++) begin
            hit_any = 1'b0;
            sel     = 2'd0;
            for (int j = 0; j < 4; j++) begin
                hit     = enq_s & lane_valid_s[j]
                        & ((tail_q + PTR_W'(lane_pos_s[j])) == PTR_W'(e));
                sel     = hit ? 2'(j) : sel;
                hit_any = hit_any | hit;
            end
            mem_d[e] = hit_any ? lane_pkt_s[sel] : mem_q[e];
        end
    end

    // Presentation of the four oldest entries; flush hides them in the same cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid_s[k] = (count_q > CNT_W'(k)) & ~flush_i;
            out_pkt_s[k]   = mem_q[head_q + PTR_W'(k)];
        end
    end

    assign decodeReady_o = out_valid_s[0];
    assign out0Valid_o   = out_valid_s[0];
    assign out1Valid_o   = out_valid_s[1];
    assign out2Valid_o   = out_valid_s[2];
    assign out3Valid_o   = out_valid_s[3];
    assign out0Packet_o  = out_pkt_s[0];
    assign out1Packet_o  = out_pkt_s[1];
    assign out2Packet_o  = out_pkt_s[2];
    assign out3Packet_o  = out_pkt_s[3];

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every visible entry.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch2_decode_queue.sv
// Randomized bench for fetch2_decode_queue, checked against a packet-queue
// reference model plus directed fill, wrap, flush and async-reset sequences.
module tb_fetch2_decode_queue;

    localparam int PKT_W = 133;
    localparam int DEPTH = 16;

    logic             clk;
    logic             reset;
    logic             fs2_ready;
    logic [3:0]       in_valid;
    logic [PKT_W-1:0] in_pkt [4];
    logic             stall;
    logic             flush;
    logic             fetch_stall;
    logic             decode_ready;
    logic [3:0]       out_valid;
    logic [PKT_W-1:0] out_pkt [4];

    logic [PKT_W-1:0] model_q [$];
    int               n_tests;
    int               n_fail;

    fetch2_decode_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .fs2Ready_i    (fs2_ready),
        .inst0Valid_i  (in_valid[0]),
        .inst1Valid_i  (in_valid[1]),
        .inst2Valid_i  (in_valid[2]),
        .inst3Valid_i  (in_valid[3]),
        .inst0Packet_i (in_pkt[0]),
        .inst1Packet_i (in_pkt[1]),
        .inst2Packet_i (in_pkt[2]),
        .inst3Packet_i (in_pkt[3]),
        .stall_i       (stall),
        .flush_i       (flush),
        .fetchStall_o  (fetch_stall),
        .decodeReady_o (decode_ready),
        .out0Valid_o   (out_valid[0]),
        .out1Valid_o   (out_valid[1]),
        .out2Valid_o   (out_valid[2]),
        .out3Valid_o   (out_valid[3]),
        .out0Packet_o  (out_pkt[0]),
        .out1Packet_o  (out_pkt[1]),
        .out2Packet_o  (out_pkt[2]),
        .out3Packet_o  (out_pkt[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [PKT_W-1:0] got,
                             input logic [PKT_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        p = '0;
        for (int i = 0; i < (PKT_W + 31) / 32; i++) begin
            p = (p << 32) | PKT_W'($urandom);
        end
        return p;
    endfunction

    // Compare every visible output against the model's view of the queue.
    task automatic check_outputs(input string phase);
        int sz;
        sz = model_q.size();
        check_val({phase, " fetchStall"}, PKT_W'(fetch_stall), PKT_W'(sz > DEPTH - 4));
        check_val({phase, " decodeReady"}, PKT_W'(decode_ready), PKT_W'((sz > 0) && !flush));
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("%s valid%0d", phase, k), PKT_W'(out_valid[k]),
                      PKT_W'((k < sz) && !flush));
            if ((k < sz) && !flush && out_valid[k]) begin
                check_val($sformatf("%s pkt%0d", phase, k), out_pkt[k], model_q[k]);
            end
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic f2, input logic [3:0] v, input logic st,
                         input logic fl, input string phase);
        bit enq_ok;
        fs2_ready = f2;
        in_valid  = v;
        stall     = st;
        flush     = fl;
        for (int k = 0; k < 4; k++) in_pkt[k] = rand_pkt();
        @(negedge clk);
        check_outputs(phase);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            enq_ok = f2 && !(model_q.size() > DEPTH - 4);
            if (!st) begin
                for (int k = 0; k < 4; k++) begin
                    if (model_q.size() > 0) void'(model_q.pop_front());
                end
            end
            if (enq_ok) begin
                for (int k = 0; k < 4; k++) begin
                    if (v[k]) model_q.push_back(in_pkt[k]);
                end
            end
        end
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        fs2_ready = 1'b0;
        in_valid  = 4'b0000;
        stall     = 1'b0;
        flush     = 1'b0;
        for (int k = 0; k < 4; k++) in_pkt[k] = '0;
        #3;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single bundle held by stall, then fill to full and try one more.
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, "first");
        for (int b = 0; b < 4; b++) cycle(1'b1, 4'b1111, 1'b1, 1'b0, "fill");
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, "full");
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, "fullhold");
        for (int b = 0; b < 5; b++) cycle(1'b0, 4'b0000, 1'b0, 1'b0, "drain");

        // Sparse valids compact, then mixed enqueue with dequeue.
        cycle(1'b1, 4'b0011, 1'b1, 1'b0, "sparse");
        cycle(1'b1, 4'b0001, 1'b1, 1'b0, "sparse");
        cycle(1'b1, 4'b1010, 1'b1, 1'b0, "sparse");
        cycle(1'b1, 4'b0111, 1'b0, 1'b0, "mixed");
        cycle(1'b0, 4'b0000, 1'b1, 1'b0, "mixed");

        // Flush with a ready bundle on the same cycle.
        cycle(1'b1, 4'b1111, 1'b1, 1'b0, "preflush");
        cycle(1'b1, 4'b1111, 1'b1, 1'b1, "flush");
        cycle(1'b0, 4'b0000, 1'b1, 1'b0, "postflush");

        // Walk the pointers around the wrap point several times.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 4'b1111, 1'b1, 1'b0, "wrapfill");
            cycle(1'b0, 4'b0000, 1'b0, 1'b0, "wrapdrain");
            cycle(1'b1, 4'(i), 1'b0, 1'b0, "wrapmix");
        end

        // Randomized traffic with occasional flush and async reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1;
                model_q.delete();
                fs2_ready = 1'b0;
                flush     = 1'b0;
                check_outputs("asyncrst");
                #1;
                reset = 1'b0;
            end
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) < 2, $urandom_range(0, 32) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
